collision_scanner: RTL and testbench

//  Frame-synchronous collision sequencer and life manager for the frog game.

---
 rtl/collision_scanner.sv | 150 +++++++++++++++
 tb/tb_collision_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/collision_scanner.sv
`default_nettype none
// ============================================================================
// collision_scanner: frame-synchronous frog/car collision sequencer and life
// manager. Optional macro EARLY_EXIT_EN ends the lane scan at the first hit.
// Revision: 1.0
// ============================================================================
module collision_scanner #(
  parameter int                     TILE_SIZE     = 32,
  parameter int                     NUM_LANES     = 5,
  parameter logic [9*NUM_LANES-1:0] LANE_Y        = {9'd320, 9'd288, 9'd192, 9'd160, 9'd128},
  parameter int                     NUM_LIVES     = 3,
  parameter int                     INVULN_FRAMES = 60
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Frame_Start,
  input  logic                    i_Restart,
  input  logic [9:0]              i_Frog_X,
  input  logic [8:0]              i_Frog_Y,
  input  logic [10*NUM_LANES-1:0] i_Cars_X,
  output logic                    o_Busy,
  output logic                    o_Scan_Done,
  output logic                    o_Hit,
  output logic [2:0]              o_Hit_Lane,
  output logic                    o_Respawn,
  output logic [2:0]              o_Lives,
  output logic                    o_Game_Over
);

  localparam logic [2:0]  LAST_LANE   = 3'(NUM_LANES - 1);
  localparam logic [2:0]  LIVES_INIT  = 3'(NUM_LIVES);
  localparam logic [7:0]  INVULN_INIT = 8'(INVULN_FRAMES);
  localparam logic [10:0] TILE        = 11'(TILE_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SNAP    = 2'd1,
    SCAN    = 2'd2,
    RESOLVE = 2'd3
  } state_t;

  state_t                    state;
  logic [2:0]                lane;
  logic                      hit_found;
  logic [2:0]                hit_idx;
  logic [7:0]                invuln;
  logic [9:0]                snap_frog_x;
  logic [8:0]                snap_frog_y;
  logic [10*NUM_LANES-1:0]   snap_cars_x;

  // Single shared comparator; operands widened to 11 bits so sums never wrap.
  logic [9:0]  cur_car_x;
  logic [8:0]  cur_lane_y;
  logic [10:0] fx, fy, cx, ly;
  logic        lane_hit;

  assign cur_car_x  = snap_cars_x[10*lane +: 10];
  assign cur_lane_y = LANE_Y[9*lane +: 9];
  assign fx = {1'b0, snap_frog_x};
  assign fy = {2'b00, snap_frog_y};
  assign cx = {1'b0, cur_car_x};
  assign ly = {2'b00, cur_lane_y};
  assign lane_hit = (fx < cx + TILE) && (fx + TILE > cx) &&
                    (fy >= ly) && (fy < ly + TILE);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= IDLE;
      lane        <= 3'd0;
      hit_found   <= 1'b0;
      hit_idx     <= 3'd0;
      invuln      <= 8'd0;
      snap_frog_x <= '0;
      snap_frog_y <= '0;
      snap_cars_x <= '0;
      o_Busy      <= 1'b0;
      o_Scan_Done <= 1'b0;
      o_Hit       <= 1'b0;
      o_Hit_Lane  <= 3'd0;
      o_Respawn   <= 1'b0;
      o_Lives     <= LIVES_INIT;
      o_Game_Over <= 1'b0;
    end else begin
      o_Scan_Done <= 1'b0;
      o_Respawn   <= 1'b0;
      if (i_Restart) begin
        state       <= IDLE;
        o_Busy      <= 1'b0;
        hit_found   <= 1'b0;
        invuln      <= 8'd0;
        o_Hit       <= 1'b0;
        o_Hit_Lane  <= 3'd0;
        o_Lives     <= LIVES_INIT;
        o_Game_Over <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_Frame_Start) begin
              state       <= SNAP;
              o_Busy      <= 1'b1;
              snap_frog_x <= i_Frog_X;
              snap_frog_y <= i_Frog_Y;
              snap_cars_x <= i_Cars_X;
              if (invuln != 8'd0) invuln <= invuln - 8'd1;
            end
          end
          SNAP: begin
            lane      <= 3'd0;
            hit_found <= 1'b0;
            hit_idx   <= 3'd0;
            state     <= SCAN;
          end
          SCAN: begin
            if (lane_hit && !hit_found) begin
              hit_found <= 1'b1;
              hit_idx   <= lane;
            end
            lane <= lane + 3'd1;
`ifdef EARLY_EXIT_EN
            if ((lane_hit && !hit_found) || lane == LAST_LANE) state <= RESOLVE;
`else
            if (lane == LAST_LANE) state <= RESOLVE;
`endif
          end
          RESOLVE: begin
            state       <= IDLE;
            o_Busy      <= 1'b0;
            o_Scan_Done <= 1'b1;
            o_Hit       <= hit_found;
            o_Hit_Lane  <= hit_found ? hit_idx : 3'd0;
            // Last life lost ends the game instead of respawning the frog.
            if (hit_found && invuln == 8'd0 && !o_Game_Over) begin
              invuln <= INVULN_INIT;
              if (o_Lives == 3'd1) begin
                o_Lives     <= 3'd0;
                o_Game_Over <= 1'b1;
              end else begin
                o_Lives   <= o_Lives - 3'd1;
                o_Respawn <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_collision_scanner.sv
`default_nettype none
// Scoreboard bench for collision_scanner: directed frames push expected
// results; a negedge monitor pops and compares on every o_Scan_Done.
module tb_collision_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        restart = 1'b0;
  logic [9:0]  frog_x = '0;
  logic [8:0]  frog_y = '0;
  logic [49:0] cars_x = '0;
  logic        busy, scan_done, hit, respawn, game_over;
  logic [2:0]  hit_lane, lives;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic       hit;
    logic [2:0] lane;
    logic       resp;
    logic [2:0] lives;
    logic       go;
    int         t;
  } exp_t;
  exp_t q[$];

  collision_scanner dut (
    .i_Clk(clk), .i_Rst(rst), .i_Frame_Start(frame_start), .i_Restart(restart),
    .i_Frog_X(frog_x), .i_Frog_Y(frog_y), .i_Cars_X(cars_x),
    .o_Busy(busy), .o_Scan_Done(scan_done), .o_Hit(hit), .o_Hit_Lane(hit_lane),
    .o_Respawn(respawn), .o_Lives(lives), .o_Game_Over(game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [49:0] one_car(input int ln, input logic [9:0] x);
    logic [49:0] v;
    v = {5{10'd700}};
    v[ln*10 +: 10] = x;
    return v;
  endfunction

  function automatic int exp_lat(input logic h, input logic [2:0] ln);
`ifdef EARLY_EXIT_EN
    return h ? int'(ln) + 3 : 7;
`else
    if (h && ln > 3'd7) return 0;
    return 7;
`endif
  endfunction

  always @(negedge clk) begin
    if (scan_done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_time", cyc, e.t);
        check("hit", int'(hit), int'(e.hit));
        check("hit_lane", int'(hit_lane), int'(e.lane));
        check("respawn", int'(respawn), int'(e.resp));
        check("lives", int'(lives), int'(e.lives));
        check("game_over", int'(game_over), int'(e.go));
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic run_frame(input logic [9:0] fx, input logic [8:0] fy, input logic [49:0] cars,
                           input logic eh, input logic [2:0] el, input logic er,
                           input logic [2:0] elv, input logic ego);
    exp_t e;
    @(negedge clk);
    frog_x = fx; frog_y = fy; cars_x = cars;
    e.hit = eh; e.lane = el; e.resp = er; e.lives = elv; e.go = ego;
    e.t = cyc + 1 + exp_lat(eh, el);
    q.push_back(e);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (10) @(negedge clk);
    check("missing_done", q.size(), 0);
    q.delete();
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  logic [49:0] far;
  exp_t        ea;

  initial begin
    far = {5{10'd700}};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(scan_done), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_lane", int'(hit_lane), 0);
    check("rst_respawn", int'(respawn), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_game_over", int'(game_over), 0);

    run_frame(10'd0, 9'd0, far, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0);
    // First hit: life lost, invulnerability window starts.
    run_frame(10'd100, 9'd160, one_car(1, 10'd90), 1'b1, 3'd1, 1'b1, 3'd2, 1'b0);
    run_frame(10'd68, 9'd160, one_car(1, 10'd100), 1'b0, 3'd0, 1'b0, 3'd2, 1'b0);
    run_frame(10'd68, 9'd160, one_car(1, 10'd99), 1'b1, 3'd1, 1'b0, 3'd2, 1'b0);
    run_frame(10'd300, 9'd330, one_car(4, 10'd290), 1'b1, 3'd4, 1'b0, 3'd2, 1'b0);
    run_frame(10'd50, 9'd159, one_car(0, 10'd50), 1'b1, 3'd0, 1'b0, 3'd2, 1'b0);
    for (int i = 0; i < 54; i++)
      run_frame(10'd0, 9'd0, far, 1'b0, 3'd0, 1'b0, 3'd2, 1'b0);
    // Frame 59 after the hit: counter still 1, protected.
    run_frame(10'd100, 9'd160, one_car(1, 10'd90), 1'b1, 3'd1, 1'b0, 3'd2, 1'b0);
    run_frame(10'd100, 9'd160, one_car(1, 10'd90), 1'b1, 3'd1, 1'b1, 3'd1, 1'b0);
    for (int i = 0; i < 59; i++)
      run_frame(10'd0, 9'd0, far, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0);
    run_frame(10'd100, 9'd160, one_car(1, 10'd90), 1'b1, 3'd1, 1'b0, 3'd0, 1'b1);
    run_frame(10'd100, 9'd160, one_car(1, 10'd90), 1'b1, 3'd1, 1'b0, 3'd0, 1'b1);

    do_restart();
    @(negedge clk);
    check("restart_lives", int'(lives), 3);
    check("restart_game_over", int'(game_over), 0);
    check("restart_hit", int'(hit), 0);
    check("restart_lane", int'(hit_lane), 0);
    check("restart_busy", int'(busy), 0);

    // Restart landing on edge T+3 aborts the scan with no done pulse.
    frog_x = 10'd100; frog_y = 9'd160; cars_x = one_car(1, 10'd90);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_mid_scan", int'(busy), 1);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("busy_after_restart", int'(busy), 0);
    repeat (10) @(negedge clk);
    check("lives_after_abort", int'(lives), 3);

    // Second frame start while busy must be ignored.
    ea.hit = 1'b1; ea.lane = 3'd1; ea.resp = 1'b1; ea.lives = 3'd2; ea.go = 1'b0;
    ea.t = cyc + 1 + exp_lat(1'b1, 3'd1);
    q.push_back(ea);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (14) @(negedge clk);
    check("missing_done_busy", q.size(), 0);
    q.delete();

    // Restart and frame start together: frame dropped.
    restart = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    frame_start = 1'b0;
    check("drop_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    check("drop_lives", int'(lives), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
